// File: rtl/cordic_phase_track_if.sv
// Sample/result bundle between the CORDIC vectoring stage and the phase tracker.
// The master drives the samples and the threshold. The slave returns the tracked results.
interface cordic_phase_track_if #(
    parameter int W_NIO   = 16,
    parameter int W_ACC   = 32,
    parameter int LOG_DEC = 4
);
    logic                     in_vld;
    logic [W_NIO-1:0]         in_ph;
    logic [W_NIO-1:0]         in_mag;
    logic [W_NIO-1:0]         mag_th;
    logic                     clr;
    logic [W_ACC-1:0]         uph;
    logic [W_NIO+LOG_DEC-1:0] frq;
    logic                     frq_vld;
    logic                     locked;
    logic                     los;

    modport master (
        output in_vld, in_ph, in_mag, mag_th, clr,
        input  uph, frq, frq_vld, locked, los
    );

    modport slave (
        input  in_vld, in_ph, in_mag, mag_th, clr,
        output uph, frq, frq_vld, locked, los
    );
endinterface

// File: rtl/cordic_phase_track.sv
// Phase tracker fed by the CORDIC core: magnitude gating, phase unwrapping,
// a decimated frequency estimate and lock tracking. Latency is two cycles.
module cordic_phase_track #(
    parameter int W_NIO   = 16,
    parameter int W_ACC   = 32,
    parameter int LOG_DEC = 4,
    parameter int LOCK_N  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cordic_phase_track_if.slave  bus
);
    localparam int W_FRQ = W_NIO + LOG_DEC;
    localparam logic [7:0] LOCK_N_C = 8'(LOCK_N);

    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

    logic             vld_q;
    logic [W_NIO-1:0] ph_q;
    logic [W_NIO-1:0] mag_q;
    logic             clr_q;

    state_t             state_q, state_d;
    logic [W_NIO-1:0]   ph_prev_q, ph_prev_d;
    logic [W_ACC-1:0]   uph_q, uph_d;
    logic [W_FRQ-1:0]   dec_acc_q, dec_acc_d;
    logic [LOG_DEC-1:0] dec_cnt_q, dec_cnt_d;
    logic [7:0]         good_cnt_q, good_cnt_d;
    logic [W_FRQ-1:0]   frq_q, frq_d;
    logic               frq_vld_q, frq_vld_d;
    logic               locked_q, locked_d;
    logic               los_q, los_d;

    logic             good_s;
    logic             bad_s;
    logic             last_s;
    logic [W_NIO-1:0] d_s;
    logic [W_ACC-1:0] d_acc_s;
    logic [W_FRQ-1:0] d_frq_s;

    // Input capture stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            ph_q  <= {W_NIO{1'b0}};
            mag_q <= {W_NIO{1'b0}};
            clr_q <= 1'b0;
        end else begin
            vld_q <= bus.in_vld;
            ph_q  <= bus.in_ph;
            mag_q <= bus.in_mag;
            clr_q <= bus.clr;
        end
    end

    // Modular subtraction wraps the step naturally into [-Pi, +Pi).
    assign good_s  = vld_q & ~mag_q[W_NIO-1] & (mag_q >= bus.mag_th);
    assign bad_s   = vld_q & ~good_s;
    assign last_s  = (dec_cnt_q == {LOG_DEC{1'b1}});
    assign d_s     = ph_q - ph_prev_q;
    assign d_acc_s = {{(W_ACC-W_NIO){d_s[W_NIO-1]}}, d_s};
    assign d_frq_s = {{LOG_DEC{d_s[W_NIO-1]}}, d_s};

    // Tracking state machine and accumulator next-state logic.
    always_comb begin
        state_d    = state_q;
        ph_prev_d  = ph_prev_q;
        uph_d      = uph_q;
        dec_acc_d  = dec_acc_q;
        dec_cnt_d  = dec_cnt_q;
        good_cnt_d = good_cnt_q;
        frq_d      = frq_q;
        frq_vld_d  = 1'b0;
        locked_d   = locked_q;
        los_d      = 1'b0;
        case (state_q)
            S_INIT: begin
                if (good_s) begin
                    ph_prev_d  = ph_q;
                    state_d    = S_RUN;
                    good_cnt_d = 8'd1;
                    locked_d   = (LOCK_N_C == 8'd1);
                end else begin
                    state_d = S_INIT;
                end
            end
            S_RUN: begin
                if (good_s) begin
                    ph_prev_d = ph_q;
                    uph_d     = uph_q + d_acc_s;
                    if (last_s) begin
                        frq_d     = dec_acc_q + d_frq_s;
                        frq_vld_d = 1'b1;
                        dec_acc_d = {W_FRQ{1'b0}};
                        dec_cnt_d = {LOG_DEC{1'b0}};
                    end else begin
                        dec_acc_d = dec_acc_q + d_frq_s;
                        dec_cnt_d = dec_cnt_q + {{(LOG_DEC-1){1'b0}}, 1'b1};
                    end
                    if (good_cnt_q < LOCK_N_C) begin
                        good_cnt_d = good_cnt_q + 8'd1;
                    end else begin
                        good_cnt_d = LOCK_N_C;
                    end
                    if (({1'b0, good_cnt_q} + 9'd1) >= {1'b0, LOCK_N_C}) begin
                        locked_d = 1'b1;
                    end else begin
                        locked_d = locked_q;
                    end
                end else if (bad_s) begin
                    state_d    = S_INIT;
                    dec_acc_d  = {W_FRQ{1'b0}};
                    dec_cnt_d  = {LOG_DEC{1'b0}};
                    good_cnt_d = 8'd0;
                    locked_d   = 1'b0;
                    los_d      = locked_q;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
        // Clear wins over this cycle's accumulation; the window is untouched.
        if (clr_q) begin
            uph_d = {W_ACC{1'b0}};
        end else begin
            uph_d = uph_d;
        end
    end

    // Update stage registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            ph_prev_q  <= {W_NIO{1'b0}};
            uph_q      <= {W_ACC{1'b0}};
            dec_acc_q  <= {W_FRQ{1'b0}};
            dec_cnt_q  <= {LOG_DEC{1'b0}};
            good_cnt_q <= 8'd0;
            frq_q      <= {W_FRQ{1'b0}};
            frq_vld_q  <= 1'b0;
            locked_q   <= 1'b0;
            los_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_prev_q  <= ph_prev_d;
            uph_q      <= uph_d;
            dec_acc_q  <= dec_acc_d;
            dec_cnt_q  <= dec_cnt_d;
            good_cnt_q <= good_cnt_d;
            frq_q      <= frq_d;
            frq_vld_q  <= frq_vld_d;
            locked_q   <= locked_d;
            los_q      <= los_d;
        end
    end

    assign bus.uph     = uph_q;
    assign bus.frq     = frq_q;
    assign bus.frq_vld = frq_vld_q;
    assign bus.locked  = locked_q;
    assign bus.los     = los_q;
endmodule

// File: tb/tb_cordic_phase_track.sv
// Directed bench for cordic_phase_track with hand-computed expectations.
module tb_cordic_phase_track;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   pulses;

    cordic_phase_track_if #(.W_NIO(16), .W_ACC(32), .LOG_DEC(4)) bus ();

    cordic_phase_track #(.W_NIO(16), .W_ACC(32), .LOG_DEC(4), .LOCK_N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle at the falling edge; frq_vld pulses seen there are counted.
    task automatic send(input logic vld, input logic [15:0] ph, input logic [15:0] mag, input logic c);
        @(negedge clk);
        if (bus.frq_vld === 1'b1) pulses++;
        bus.in_vld = vld;
        bus.in_ph  = ph;
        bus.in_mag = mag;
        bus.clr    = c;
    endtask

    task automatic idle();
        send(1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic ramp(input logic [15:0] start, input logic [15:0] step, input int n);
        logic [15:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            send(1'b1, p, 16'h4000, 1'b0);
            p = p + step;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_vld = 1'b0;
        bus.clr    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.in_vld = 1'b1;
        bus.in_ph  = 16'h1234;
        bus.in_mag = 16'h4000;
        bus.mag_th = 16'h1000;
        bus.clr    = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (bus.uph !== 32'h0) begin fails++; $display("FAIL rst_uph got %h want %h", bus.uph, 32'h0); end
        tests++; if (bus.frq !== 20'h0) begin fails++; $display("FAIL rst_frq got %h want %h", bus.frq, 20'h0); end
        tests++; if ({bus.frq_vld, bus.locked, bus.los} !== 3'b000) begin fails++; $display("FAIL rst_flags got %b want 000", {bus.frq_vld, bus.locked, bus.los}); end
        bus.in_vld = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_ramp();
        do_reset();
        ramp(16'h0000, 16'h0100, 17);
        idle();
        idle();
        tests++; if (bus.frq_vld !== 1'b1) begin fails++; $display("FAIL ramp_vld got %b want 1", bus.frq_vld); end
        tests++; if (bus.frq !== 20'h01000) begin fails++; $display("FAIL ramp_frq got %h want %h", bus.frq, 20'h01000); end
        tests++; if (bus.uph !== 32'h00001000) begin fails++; $display("FAIL ramp_uph got %h want %h", bus.uph, 32'h00001000); end
        tests++; if (bus.locked !== 1'b1) begin fails++; $display("FAIL ramp_locked got %b want 1", bus.locked); end
        idle();
        tests++; if (bus.frq_vld !== 1'b0) begin fails++; $display("FAIL ramp_vld_pulse got %b want 0", bus.frq_vld); end
    endtask

    task automatic test_wrap();
        do_reset();
        send(1'b1, 16'h7F00, 16'h4000, 1'b0);
        send(1'b1, 16'h8100, 16'h4000, 1'b0);
        idle();
        idle();
        tests++; if (bus.uph !== 32'h00000200) begin fails++; $display("FAIL wrap_uph got %h want %h", bus.uph, 32'h00000200); end
    endtask

    task automatic test_negative();
        do_reset();
        ramp(16'h0000, 16'hFF00, 17);
        idle();
        idle();
        tests++; if (bus.frq_vld !== 1'b1) begin fails++; $display("FAIL neg_vld got %b want 1", bus.frq_vld); end
        tests++; if (bus.frq !== 20'hFF000) begin fails++; $display("FAIL neg_frq got %h want %h", bus.frq, 20'hFF000); end
        tests++; if (bus.uph !== 32'hFFFFF000) begin fails++; $display("FAIL neg_uph got %h want %h", bus.uph, 32'hFFFFF000); end
    endtask

    task automatic test_loss();
        do_reset();
        ramp(16'h0000, 16'h0100, 10);
        idle();
        idle();
        tests++; if (bus.locked !== 1'b1) begin fails++; $display("FAIL loss_pre_locked got %b want 1", bus.locked); end
        send(1'b1, 16'h0A00, 16'h0800, 1'b0);
        idle();
        idle();
        tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL loss_locked got %b want 0", bus.locked); end
        tests++; if (bus.los !== 1'b1) begin fails++; $display("FAIL loss_los got %b want 1", bus.los); end
        tests++; if (bus.frq_vld !== 1'b0) begin fails++; $display("FAIL loss_frq_vld got %b want 0", bus.frq_vld); end
        tests++; if (bus.uph !== 32'h00000900) begin fails++; $display("FAIL loss_uph got %h want %h", bus.uph, 32'h00000900); end
        idle();
        tests++; if (bus.los !== 1'b0) begin fails++; $display("FAIL loss_los_pulse got %b want 0", bus.los); end
        send(1'b1, 16'h5000, 16'h4000, 1'b0);
        idle();
        idle();
        tests++; if (bus.uph !== 32'h00000900) begin fails++; $display("FAIL reinit_uph got %h want %h", bus.uph, 32'h00000900); end
        ramp(16'h5100, 16'h0100, 6);
        idle();
        idle();
        tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL relock_early got %b want 0", bus.locked); end
        send(1'b1, 16'h5700, 16'h4000, 1'b0);
        idle();
        idle();
        tests++; if (bus.locked !== 1'b1) begin fails++; $display("FAIL relock got %b want 1", bus.locked); end
        tests++; if (bus.uph !== 32'h00001000) begin fails++; $display("FAIL relock_uph got %h want %h", bus.uph, 32'h00001000); end
    endtask

    task automatic test_clr();
        do_reset();
        ramp(16'h0000, 16'h0100, 3);
        send(1'b1, 16'h0300, 16'h4000, 1'b1);
        idle();
        idle();
        tests++; if (bus.uph !== 32'h0) begin fails++; $display("FAIL clr_uph got %h want %h", bus.uph, 32'h0); end
        ramp(16'h0400, 16'h0100, 13);
        idle();
        idle();
        tests++; if (bus.frq_vld !== 1'b1) begin fails++; $display("FAIL clr_vld got %b want 1", bus.frq_vld); end
        tests++; if (bus.frq !== 20'h01000) begin fails++; $display("FAIL clr_frq got %h want %h", bus.frq, 20'h01000); end
        tests++; if (bus.uph !== 32'h00000D00) begin fails++; $display("FAIL clr_uph_after got %h want %h", bus.uph, 32'h00000D00); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ramp(16'h0000, 16'h0100, 8);
        idle();
        idle();
        tests++; if (bus.uph !== 32'h00000700) begin fails++; $display("FAIL mid_pre_uph got %h want %h", bus.uph, 32'h00000700); end
        do_reset();
        tests++; if (bus.uph !== 32'h0) begin fails++; $display("FAIL mid_rst_uph got %h want %h", bus.uph, 32'h0); end
        tests++; if ({bus.frq_vld, bus.locked, bus.los} !== 3'b000) begin fails++; $display("FAIL mid_rst_flags got %b want 000", {bus.frq_vld, bus.locked, bus.los}); end
        tests++; if (bus.frq !== 20'h0) begin fails++; $display("FAIL mid_rst_frq got %h want %h", bus.frq, 20'h0); end
        pulses = 0;
        ramp(16'h3000, 16'h0100, 17);
        idle();
        idle();
        tests++; if (bus.frq !== 20'h01000) begin fails++; $display("FAIL mid_frq got %h want %h", bus.frq, 20'h01000); end
        idle();
        idle();
        tests++; if (pulses !== 1) begin fails++; $display("FAIL mid_pulses got %0d want 1", pulses); end
        tests++; if (bus.uph !== 32'h00001000) begin fails++; $display("FAIL mid_uph got %h want %h", bus.uph, 32'h00001000); end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        pulses = 0;
        test_reset();
        test_ramp();
        test_wrap();
        test_negative();
        test_loss();
        test_clr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
